// File: rtl/serializer_pkg.sv
// Shared SD command definitions: frame length and derived bit-counter width.
package serializer_pkg;

  localparam int CMD_FRAME_W = 48;
  localparam int CMD_CNT_W   = $clog2(CMD_FRAME_W);

endpackage

// File: rtl/serializer.sv
// Purpose: free-running MSB-first parallel-to-serial converter for the SD CMD line.
// Latency: bit k of the frame appears after k enabled edges; out is a live mux of in.
// Backpressure: enable=0 freezes the bit counter so out holds the current bit.
module serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = CMD_FRAME_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in,
  output logic             out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // cnt never exceeds LAST, so idx always selects a real bit of in.
  assign idx = LAST - cnt;
  assign out = in[idx];

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: async reset, shift order, wrap, hold, mid-frame reset, live input.
`timescale 1ns/1ps
module tb_serializer;

  localparam int W = 48;
  localparam logic [W-1:0] FRAME = 48'hAD7AEBAAAA75;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [W-1:0] in;
  logic         out;

  int n_assert;
  int n_fail;

  serializer #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .in     (in),
    .out    (out)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge where outputs are sampled and inputs driven.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] f;
    logic [W-1:0] g;
    f = FRAME;
    g = ~FRAME;
    n_assert = 0;
    n_fail   = 0;
    reset  = 1'b1;
    enable = 1'b1;
    in     = f;

    // Asynchronous reset before the first rising edge (t=1).
    #0.25 reset = 1'b0;
    #0.25;
    check_bit("async_reset_out", out, 1'b1);
    check_cnt("async_reset_cnt", dut.cnt, 6'd0);

    // Reset dominates enable.
    for (int i = 0; i < 3; i++) begin
      step();
      check_bit("reset_over_enable_out", out, 1'b1);
      check_cnt("reset_over_enable_cnt", dut.cnt, 6'd0);
    end

    // Hand-computed head and tail of the frame.
    reset = 1'b1;
    check_bit("shift_edge0", out, 1'b1);
    step(); check_bit("shift_edge1", out, 1'b0);
    step(); check_bit("shift_edge2", out, 1'b1);
    step(); check_bit("shift_edge3", out, 1'b0);
    step(); check_bit("shift_edge4", out, 1'b1);
    step(); check_bit("shift_edge5", out, 1'b1);
    step(); check_bit("shift_edge6", out, 1'b0);
    step(); check_bit("shift_edge7", out, 1'b1);
    for (int k = 8; k < 44; k++) begin
      step();
      check_bit($sformatf("shift_edge%0d", k), out, f[W-1-k]);
    end
    step(); check_bit("shift_edge44", out, 1'b0);
    step(); check_bit("shift_edge45", out, 1'b1);
    step(); check_bit("shift_edge46", out, 1'b0);
    step(); check_bit("shift_edge47", out, 1'b1);
    check_cnt("last_bit_cnt", dut.cnt, 6'd47);

    // Wrap and repeat the whole frame.
    step();
    check_bit("wrap_out", out, 1'b1);
    check_cnt("wrap_cnt", dut.cnt, 6'd0);
    for (int k = 1; k < W; k++) begin
      step();
      check_bit($sformatf("repeat_edge%0d", k), out, f[W-1-k]);
    end

    // Advance into the next frame up to bit index 5, then hold.
    step();
    check_bit("frame3_msb", out, 1'b1);
    for (int k = 1; k <= 5; k++) step();
    check_bit("hold_start", out, 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_bit("hold_out", out, 1'b1);
      check_cnt("hold_cnt", dut.cnt, 6'd5);
    end
    enable = 1'b1;
    step();
    check_bit("resume_bit41", out, 1'b0);
    for (int k = 7; k <= 20; k++) begin
      step();
      check_bit($sformatf("pre_reset_edge%0d", k), out, f[W-1-k]);
    end
    check_cnt("pre_reset_cnt", dut.cnt, 6'd20);

    // Mid-frame reset takes effect without a clock edge.
    reset = 1'b0;
    #0.2;
    check_bit("midframe_reset_out", out, 1'b1);
    check_cnt("midframe_reset_cnt", dut.cnt, 6'd0);
    @(negedge clk);
    reset = 1'b1;
    check_bit("restart_edge0", out, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step();
      check_bit($sformatf("restart_edge%0d", k), out, f[W-1-k]);
    end

    // Live input change is visible immediately on out.
    in = g;
    #0.2;
    check_bit("live_input_change", out, g[W-1-8]);
    check_bit("live_input_value", out, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
